frame_packer: RTL and testbench
===============================

FRAME_PACKER -- requirements
Module: frame_packer

Interface
REQ-001 SHALL have parameter HEAD, default 32'h7FFF7FFF, frame header word sent LSB first.
REQ-002 SHALL have parameter NUM_DIGITAL, default 2, digital channel count (0..63).
REQ-003 SHALL have parameter NUM_ANALOG, default 14, analog channel count (1..192); NUM_DIGITAL+NUM_ANALOG SHALL be <= 255.
REQ-004 SHALL have parameter AD_WIDTH, default 14, analog sample width (1..16).
REQ-005 SHALL have parameter FIFO_AW, default 12, width of the TX FIFO fill-level input.
REQ-006 SHALL have parameter FIFO_THRESH, default 2000, fill level at or above which writes stall.
REQ-007 clk  in  1  system clock; all logic on posedge clk.
REQ-008 rst  in  1  asynchronous, active-low reset.
REQ-009 ena  in  1  enables acceptance of frame_start.
REQ-010 frame_start  in  1  one-cycle request to emit one frame.
REQ-011 frame_cnt  in  16  frame sequence number.
REQ-012 digital  in  NUM_DIGITAL  active-low digital inputs.
REQ-013 ad_dat  in  NUM_ANALOG*AD_WIDTH  analog samples; channel k at bits [k*AD_WIDTH +: AD_WIDTH].
REQ-014 tx_fifo_usedw  in  FIFO_AW  TX FIFO fill level.
REQ-015 tx_fifo_wen  out  1  byte write strobe.
REQ-016 tx_fifo_wdata  out  8  byte, valid in the same cycle as tx_fifo_wen.
REQ-017 busy  out  1  high from frame acceptance until the last byte is written.
REQ-018 overrun  out  1  one-cycle pulse when frame_start is dropped.

Function
REQ-019 frame_start SHALL be accepted only when ena=1 and busy=0; on acceptance frame_cnt, digital and ad_dat SHALL be snapshotted into internal registers, and the frame SHALL be built only from the snapshot.
REQ-020 Frame byte order SHALL be: HEAD[7:0], [15:8], [23:16], [31:24]; frame_cnt lo, hi; NUM_SIGNAL lo, hi (NUM_SIGNAL=NUM_DIGITAL+NUM_ANALOG); then one 4-byte record per signal.
REQ-021 Record i SHALL be: index i (8-bit, digital channels first, then analog channels 0..NUM_ANALOG-1); tag 8'h33 for digital or 8'hCC for analog; data lo; data hi.
REQ-022 Digital data SHALL be 16'h000X with bit0 = ~digital[j]; analog data SHALL be the sample zero-extended to 16 bits.
REQ-023 State machine SHALL have the states IDLE -> HDR (8 bytes) -> BODY (4*NUM_SIGNAL bytes) -> [CKS] -> IDLE; byte counters SHALL clear on acceptance.
REQ-024 The first tx_fifo_wen SHALL be asserted in the cycle after acceptance, provided tx_fifo_usedw < FIFO_THRESH; thereafter the block SHALL emit one byte per cycle while tx_fifo_usedw < FIFO_THRESH.
REQ-025 While tx_fifo_usedw >= FIFO_THRESH, tx_fifo_wen SHALL be 0 and the byte pointer SHALL hold; resumption SHALL lose and duplicate no byte.
REQ-026 busy SHALL fall in the cycle after the final byte's wen; a frame_start in that same falling cycle SHALL be accepted.
REQ-027 frame_start while busy=1 SHALL be dropped and SHALL assert overrun for one cycle; the frame in progress SHALL be unaffected.
REQ-028 ena falling mid-frame SHALL NOT abort the frame; frame_start with ena=0 SHALL be ignored silently.
REQ-029 tx_fifo_wdata SHALL hold its last value while wen=0.

Reset
REQ-030 While rst=0: state=IDLE; tx_fifo_wen=0, tx_fifo_wdata=0, busy=0, overrun=0; counters and snapshot = 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately; no further bytes SHALL be written after reset release until a new frame_start.

Configuration
REQ-032 Macro FRAME_PACKER_CHECKSUM_EN defined: state CKS SHALL append one byte = sum modulo 256 of all preceding frame bytes; frame length = 9+4*NUM_SIGNAL.
REQ-033 Macro not defined: no CKS state and no checksum logic; frame length = 8+4*NUM_SIGNAL.

Verification (defaults, no usedw stall unless stated)
REQ-034 Hold rst=0 with random inputs -> all outputs 0; release rst with no frame_start -> wen stays 0.
REQ-035 frame_cnt=16'h0102, digital=2'b01, ad ch0=14'h1ABC -> bytes FF 7F FF 7F 02 01 10 00 | 00 33 00 00 | 01 33 01 00 | 02 CC BC 1A ...; 72 wen cycles contiguous; busy falls one cycle after the last wen.
REQ-036 usedw=2000 from byte 10 for 5 cycles -> no wen for those 5 cycles; bytes 10..71 then follow in order; 72 total.
REQ-037 frame_start at byte 30 -> overrun=1 for exactly one cycle; one frame only, content unchanged.
REQ-038 ad ch0 changed to 14'h0001 at byte 5 -> record 2 still carries BC 1A.
REQ-039 FRAME_PACKER_CHECKSUM_EN defined, REQ-035 stimulus -> 73 bytes; byte 72 = sum mod 256 of bytes 0..71.

Source files
------------

// File: rtl/frame_packer_if.sv
// frame_packer_if: TX FIFO write port. frame_packer drives the master side,
// the FIFO (or a bench) drives the slave side and reports its fill level.
interface frame_packer_if #(
  parameter int FIFO_AW = 12
) ();
  logic               tx_fifo_wen;
  logic [7:0]         tx_fifo_wdata;
  logic [FIFO_AW-1:0] tx_fifo_usedw;

  modport master (
    output tx_fifo_wen,
    output tx_fifo_wdata,
    input  tx_fifo_usedw
  );

  modport slave (
    input  tx_fifo_wen,
    input  tx_fifo_wdata,
    output tx_fifo_usedw
  );
endinterface

// File: rtl/frame_packer.sv
// frame_packer: snapshots digital/analog channels on frame_start and writes a framed
// byte stream to a TX FIFO. Define FRAME_PACKER_CHECKSUM_EN to append a mod-256 sum byte.
module frame_packer #(
  parameter logic [31:0] HEAD        = 32'h7FFF7FFF,
  parameter int          NUM_DIGITAL = 2,
  parameter int          NUM_ANALOG  = 14,
  parameter int          AD_WIDTH    = 14,
  parameter int          FIFO_AW     = 12,
  parameter int          FIFO_THRESH = 2000,
  localparam int         DIG_W       = (NUM_DIGITAL > 0) ? NUM_DIGITAL : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ena,
  input  logic                           frame_start,
  input  logic [15:0]                    frame_cnt,
  input  logic [DIG_W-1:0]               digital,
  input  logic [NUM_ANALOG*AD_WIDTH-1:0] ad_dat,
  frame_packer_if.master                 tx,
  output logic                           busy,
  output logic                           overrun
);

  localparam int          NUM_SIGNAL = NUM_DIGITAL + NUM_ANALOG;
  localparam logic [7:0]  LAST_IDX   = 8'(NUM_SIGNAL - 1);
  localparam logic [7:0]  NUM_DIG8   = 8'(NUM_DIGITAL);
  localparam logic [15:0] NUM_SIG16  = 16'(NUM_SIGNAL);
  localparam logic [31:0] THRESH_U   = 32'(FIFO_THRESH);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    BODY
`ifdef FRAME_PACKER_CHECKSUM_EN
    , CKS
`endif
  } state_e;

  state_e                          state_q;
  logic                            busy_q;
  logic                            overrun_q;
  logic [2:0]                      hdr_cnt_q;
  logic [1:0]                      rec_byte_q;
  logic [7:0]                      sig_idx_q;
  logic [7:0]                      wdata_q;
  logic [7:0]                      wdata_d;
  logic [15:0]                     cnt_q;
  logic [DIG_W-1:0]                dig_q;
  logic [NUM_ANALOG*AD_WIDTH-1:0]  ad_q;
`ifdef FRAME_PACKER_CHECKSUM_EN
  logic [7:0]                      cks_q;
`endif

  logic [FIFO_AW-1:0] usedw;
  logic               fifo_ok;
  logic               wen;
  logic               accept;
  logic [15:0]        sig_word [256];

  assign usedw   = tx.tx_fifo_usedw;
  assign fifo_ok = 32'(usedw) < THRESH_U;
  assign wen     = (state_q != IDLE) && fifo_ok;
  assign accept  = frame_start && ena && !busy_q;

  // Record data words indexed by signal number; entries past NUM_SIGNAL are never addressed.
  genvar gi;
  generate
    for (gi = 0; gi < 256; gi++) begin : g_sig
      if (gi < NUM_DIGITAL) begin : g_dig
        assign sig_word[gi] = {15'd0, ~dig_q[gi]};
      end else if (gi < NUM_SIGNAL) begin : g_ana
        assign sig_word[gi] = 16'(ad_q[(gi - NUM_DIGITAL)*AD_WIDTH +: AD_WIDTH]);
      end else begin : g_pad
        assign sig_word[gi] = 16'd0;
      end
    end
  endgenerate

  always_comb begin
    wdata_d = 8'h00;
    case (state_q)
      HDR: begin
        case (hdr_cnt_q)
          3'd0:    wdata_d = HEAD[7:0];
          3'd1:    wdata_d = HEAD[15:8];
          3'd2:    wdata_d = HEAD[23:16];
          3'd3:    wdata_d = HEAD[31:24];
          3'd4:    wdata_d = cnt_q[7:0];
          3'd5:    wdata_d = cnt_q[15:8];
          3'd6:    wdata_d = NUM_SIG16[7:0];
          default: wdata_d = NUM_SIG16[15:8];
        endcase
      end
      BODY: begin
        case (rec_byte_q)
          2'd0:    wdata_d = sig_idx_q;
          2'd1:    wdata_d = (sig_idx_q < NUM_DIG8) ? 8'h33 : 8'hCC;
          2'd2:    wdata_d = sig_word[sig_idx_q][7:0];
          default: wdata_d = sig_word[sig_idx_q][15:8];
        endcase
      end
`ifdef FRAME_PACKER_CHECKSUM_EN
      CKS:     wdata_d = cks_q;
`endif
      default: wdata_d = 8'h00;
    endcase
  end

  // A stalled cycle leaves every counter untouched, so the same byte is re-offered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      hdr_cnt_q  <= 3'd0;
      rec_byte_q <= 2'd0;
      sig_idx_q  <= 8'd0;
      wdata_q    <= 8'h00;
      cnt_q      <= 16'h0000;
      dig_q      <= '0;
      ad_q       <= '0;
`ifdef FRAME_PACKER_CHECKSUM_EN
      cks_q      <= 8'h00;
`endif
    end else begin
      overrun_q <= frame_start && ena && busy_q;
      if (wen) begin
        wdata_q <= wdata_d;
`ifdef FRAME_PACKER_CHECKSUM_EN
        cks_q   <= cks_q + wdata_d;
`endif
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q    <= HDR;
            busy_q     <= 1'b1;
            hdr_cnt_q  <= 3'd0;
            rec_byte_q <= 2'd0;
            sig_idx_q  <= 8'd0;
            cnt_q      <= frame_cnt;
            dig_q      <= digital;
            ad_q       <= ad_dat;
`ifdef FRAME_PACKER_CHECKSUM_EN
            cks_q      <= 8'h00;
`endif
          end
        end
        HDR: begin
          if (wen) begin
            hdr_cnt_q <= hdr_cnt_q + 3'd1;
            if (hdr_cnt_q == 3'd7) begin
              state_q <= BODY;
            end
          end
        end
        BODY: begin
          if (wen) begin
            rec_byte_q <= rec_byte_q + 2'd1;
            if (rec_byte_q == 2'd3) begin
              sig_idx_q <= sig_idx_q + 8'd1;
              if (sig_idx_q == LAST_IDX) begin
`ifdef FRAME_PACKER_CHECKSUM_EN
                state_q <= CKS;
`else
                state_q <= IDLE;
                busy_q  <= 1'b0;
`endif
              end
            end
          end
        end
`ifdef FRAME_PACKER_CHECKSUM_EN
        CKS: begin
          if (wen) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
`endif
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx.tx_fifo_wen   = wen;
  assign tx.tx_fifo_wdata = wen ? wdata_d : wdata_q;
  assign busy             = busy_q;
  assign overrun          = overrun_q;

endmodule

// File: tb/tb_frame_packer.sv
// Bench for frame_packer: random frames compared with a byte-list model built from the
// frame layout rules, plus stall, overrun, snapshot, ena, back-to-back and reset cases.
module tb_frame_packer;
  localparam int ND = 2;
  localparam int NA = 14;
  localparam int AW = 14;
  localparam int NS = ND + NA;
  localparam int THRESH = 2000;
  localparam logic [31:0] HEAD_W = 32'h7FFF7FFF;
`ifdef FRAME_PACKER_CHECKSUM_EN
  localparam int FLEN = 9 + 4*NS;
`else
  localparam int FLEN = 8 + 4*NS;
`endif

  typedef logic [7:0] bq_t [$];
  typedef logic [NA*AW-1:0] ad_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ena = 1'b0;
  logic          frame_start = 1'b0;
  logic [15:0]   frame_cnt = 16'h0000;
  logic [ND-1:0] digital = '0;
  ad_t           ad_dat = '0;
  logic          busy;
  logic          overrun;

  frame_packer_if #(.FIFO_AW(12)) tx_if ();

  frame_packer dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .frame_start (frame_start),
    .frame_cnt   (frame_cnt),
    .digital     (digital),
    .ad_dat      (ad_dat),
    .tx          (tx_if.master),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  // Monitor state, sampled on the falling edge.
  bq_t        got;
  int         wen_cyc [$];
  int         viol = 0;
  int         hold_viol = 0;
  int         ov_cnt = 0;
  int         ov_cyc = -1;
  int         busy_fall_cyc = -1;
  logic       busy_prev = 1'b0;
  logic [7:0] last_byte = 8'h00;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) last_byte = 8'h00;
    if (tx_if.tx_fifo_wen === 1'b1) begin
      got.push_back(tx_if.tx_fifo_wdata);
      wen_cyc.push_back(cyc);
      if (int'(tx_if.tx_fifo_usedw) >= THRESH) viol++;
      last_byte = tx_if.tx_fifo_wdata;
    end else if (rst && tx_if.tx_fifo_wdata !== last_byte) begin
      hold_viol++;
    end
    if (overrun === 1'b1) begin
      ov_cnt++;
      ov_cyc = cyc;
    end
    if (busy_prev === 1'b1 && busy === 1'b0) busy_fall_cyc = cyc;
    busy_prev = busy;
  end

  task automatic clear_mon();
    got.delete();
    wen_cyc.delete();
    viol = 0;
    hold_viol = 0;
    ov_cnt = 0;
    ov_cyc = -1;
    busy_fall_cyc = -1;
  endtask

  function automatic ad_t rand_ad();
    ad_t a;
    for (int k = 0; k < NA; k++) a[k*AW +: AW] = AW'($urandom);
    return a;
  endfunction

  // Reference frame: header, count, signal count, then one record per signal.
  function automatic bq_t model_frame(input logic [15:0] c, input logic [ND-1:0] d, input ad_t a);
    bq_t q;
    int sum = 0;
    int data;
    ad_t sh;
    for (int k = 0; k < 4; k++) q.push_back(8'((HEAD_W >> (8*k)) & 32'hFF));
    q.push_back(c[7:0]);
    q.push_back(c[15:8]);
    q.push_back(8'(NS % 256));
    q.push_back(8'(NS / 256));
    for (int i = 0; i < NS; i++) begin
      q.push_back(8'(i));
      if (i < ND) begin
        q.push_back(8'h33);
        data = d[i] ? 0 : 1;
      end else begin
        q.push_back(8'hCC);
        sh = a >> ((i - ND)*AW);
        data = int'(sh[15:0]) % (1 << AW);
      end
      q.push_back(8'(data % 256));
      q.push_back(8'(data / 256));
    end
`ifdef FRAME_PACKER_CHECKSUM_EN
    foreach (q[j]) sum += int'(q[j]);
    q.push_back(8'(sum % 256));
`endif
    return q;
  endfunction

  function automatic int first_diff(input bq_t a, input bq_t b);
    int n = (a.size() < b.size()) ? a.size() : b.size();
    for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
    if (a.size() != b.size()) return n;
    return -1;
  endfunction

  function automatic logic [7:0] qat(input bq_t q, input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return 8'hxx;
  endfunction

  task automatic start_frame(input logic [15:0] c, input logic [ND-1:0] d, input ad_t a, output int scyc);
    @(posedge clk); #1;
    frame_cnt = c;
    digital = d;
    ad_dat = a;
    ena = 1'b1;
    frame_start = 1'b1;
    scyc = cyc;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (busy !== 1'b0) $display("FAIL %s_timeout busy=%b want 0 after %0d cycles", name, busy, n);
    else n_pass++;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic wait_bytes(input int nb);
    int n = 0;
    while (got.size() < nb && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    logic [10:0] obs = '0;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      frame_start = 1'($urandom);
      ena = 1'($urandom);
      frame_cnt = 16'($urandom);
      digital = ND'($urandom);
      ad_dat = rand_ad();
      tx_if.tx_fifo_usedw = 12'($urandom_range(0, THRESH - 1));
      @(negedge clk);
      if ({tx_if.tx_fifo_wen, tx_if.tx_fifo_wdata, busy, overrun} !== 11'd0) begin
        bad++;
        obs = {tx_if.tx_fifo_wen, tx_if.tx_fifo_wdata, busy, overrun};
      end
    end
    n_checks++;
    if (bad != 0) $display("FAIL reset_outputs %0d cycles nonzero, last {wen,wdata,busy,ovr}=%h want 0", bad, obs);
    else n_pass++;
    @(posedge clk); #1;
    frame_start = 1'b0;
    ena = 1'b1;
    tx_if.tx_fifo_usedw = '0;
    clear_mon();
    rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    n_checks++;
    if (got.size() != 0) $display("FAIL reset_release_idle wen count=%0d want 0", got.size());
    else n_pass++;
    $display("reset: held 8 cycles, released, %0d bytes seen", got.size());
  endtask

  task automatic test_basic();
    logic [7:0] lit [20] = '{8'hFF, 8'h7F, 8'hFF, 8'h7F, 8'h02, 8'h01, 8'h10, 8'h00,
                             8'h00, 8'h33, 8'h00, 8'h00, 8'h01, 8'h33, 8'h01, 8'h00,
                             8'h02, 8'hCC, 8'hBC, 8'h1A};
    ad_t a = rand_ad();
    int s;
    int bad_i = -1;
    int d;
    int span;
    bq_t exp;
    a[0 +: AW] = 14'h1ABC;
    tx_if.tx_fifo_usedw = 12'($urandom_range(0, THRESH - 1));
    clear_mon();
    start_frame(16'h0102, 2'b01, a, s);
    wait_idle("basic");
    for (int i = 0; i < 20; i++) begin
      if (qat(got, i) !== lit[i]) begin
        bad_i = i;
        break;
      end
    end
    n_checks++;
    if (bad_i >= 0) $display("FAIL basic_literal byte %0d got %h want %h", bad_i, qat(got, bad_i), lit[bad_i]);
    else n_pass++;
    exp = model_frame(16'h0102, 2'b01, a);
    d = first_diff(got, exp);
    n_checks++;
    if (d != -1) $display("FAIL basic_frame byte %0d got %h want %h (len %0d want %0d)", d, qat(got, d), qat(exp, d), got.size(), exp.size());
    else n_pass++;
    n_checks++;
    if (wen_cyc.size() == 0 || wen_cyc[0] !== s + 1) $display("FAIL basic_latency first wen cycle %0d want %0d", (wen_cyc.size() > 0) ? wen_cyc[0] : -1, s + 1);
    else n_pass++;
    span = (wen_cyc.size() == FLEN) ? (wen_cyc[FLEN-1] - wen_cyc[0]) : -1;
    n_checks++;
    if (span != FLEN - 1) $display("FAIL basic_contiguous wen span %0d want %0d (count %0d)", span, FLEN - 1, wen_cyc.size());
    else n_pass++;
    n_checks++;
    if (wen_cyc.size() == 0 || busy_fall_cyc !== wen_cyc[wen_cyc.size()-1] + 1)
      $display("FAIL basic_busy_fall cycle %0d want %0d", busy_fall_cyc, (wen_cyc.size() > 0) ? wen_cyc[wen_cyc.size()-1] + 1 : -1);
    else n_pass++;
    n_checks++;
    if (hold_viol != 0) $display("FAIL basic_wdata_hold changes while idle %0d want 0", hold_viol);
    else n_pass++;
    $display("basic: cnt=0102 bytes=%0d", got.size());
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 3; f++) begin
      logic [15:0] c = 16'($urandom);
      logic [ND-1:0] dg = ND'($urandom);
      ad_t a = rand_ad();
      int s;
      int d;
      bq_t exp;
      clear_mon();
      start_frame(c, dg, a, s);
      wait_idle("random");
      exp = model_frame(c, dg, a);
      d = first_diff(got, exp);
      n_checks++;
      if (d != -1) $display("FAIL random_frame%0d byte %0d got %h want %h (len %0d want %0d)", f, d, qat(got, d), qat(exp, d), got.size(), exp.size());
      else n_pass++;
      $display("random: cnt=%h dig=%b bytes=%0d", c, dg, got.size());
    end
  endtask

  task automatic test_stall();
    logic [15:0] c = 16'($urandom);
    logic [ND-1:0] dg = ND'($urandom);
    ad_t a = rand_ad();
    int s;
    int d;
    int gap;
    bq_t exp;
    tx_if.tx_fifo_usedw = '0;
    clear_mon();
    start_frame(c, dg, a, s);
    wait_bytes(10);
    tx_if.tx_fifo_usedw = 12'(THRESH);
    repeat (5) @(posedge clk);
    #1;
    tx_if.tx_fifo_usedw = '0;
    n_checks++;
    if (got.size() != 10 || viol != 0) $display("FAIL stall_hold bytes %0d want 10, wen-while-full %0d want 0", got.size(), viol);
    else n_pass++;
    wait_idle("stall");
    exp = model_frame(c, dg, a);
    d = first_diff(got, exp);
    n_checks++;
    if (d != -1) $display("FAIL stall_frame byte %0d got %h want %h (len %0d want %0d)", d, qat(got, d), qat(exp, d), got.size(), exp.size());
    else n_pass++;
    gap = (wen_cyc.size() > 10) ? wen_cyc[10] - wen_cyc[9] : -1;
    n_checks++;
    if (gap != 6) $display("FAIL stall_gap byte9->byte10 cycles %0d want 6", gap);
    else n_pass++;
    $display("stall: cnt=%h bytes=%0d gap=%0d", c, got.size(), gap);
  endtask

  task automatic test_stall_random();
    logic [15:0] c = 16'($urandom);
    logic [ND-1:0] dg = ND'($urandom);
    ad_t a = rand_ad();
    int s;
    int d;
    int n = 0;
    bq_t exp;
    tx_if.tx_fifo_usedw = '0;
    clear_mon();
    start_frame(c, dg, a, s);
    while (busy === 1'b1 && n < 3000) begin
      tx_if.tx_fifo_usedw = 12'($urandom_range(THRESH - 3, THRESH + 2));
      @(posedge clk); #1;
      n++;
    end
    tx_if.tx_fifo_usedw = '0;
    wait_idle("stall_random");
    n_checks++;
    if (viol != 0 || hold_viol != 0) $display("FAIL stall_random_wen wen-while-full %0d, wdata changes %0d, want 0/0", viol, hold_viol);
    else n_pass++;
    exp = model_frame(c, dg, a);
    d = first_diff(got, exp);
    n_checks++;
    if (d != -1) $display("FAIL stall_random_frame byte %0d got %h want %h (len %0d want %0d)", d, qat(got, d), qat(exp, d), got.size(), exp.size());
    else n_pass++;
    $display("stall_random: cnt=%h bytes=%0d cycles=%0d", c, got.size(), n);
  endtask

  task automatic test_overrun();
    logic [15:0] c = 16'($urandom);
    logic [ND-1:0] dg = ND'($urandom);
    ad_t a = rand_ad();
    int s;
    int d;
    int pcyc;
    bq_t exp;
    clear_mon();
    start_frame(c, dg, a, s);
    wait_bytes(30);
    frame_start = 1'b1;
    frame_cnt = ~c;
    ad_dat = rand_ad();
    pcyc = cyc;
    @(posedge clk); #1;
    frame_start = 1'b0;
    wait_idle("overrun");
    n_checks++;
    if (ov_cnt != 1 || ov_cyc != pcyc + 1) $display("FAIL overrun_pulse count %0d at cycle %0d, want 1 at %0d", ov_cnt, ov_cyc, pcyc + 1);
    else n_pass++;
    exp = model_frame(c, dg, a);
    d = first_diff(got, exp);
    n_checks++;
    if (d != -1) $display("FAIL overrun_frame byte %0d got %h want %h (len %0d want %0d)", d, qat(got, d), qat(exp, d), got.size(), exp.size());
    else n_pass++;
    $display("overrun: cnt=%h bytes=%0d overruns=%0d", c, got.size(), ov_cnt);
  endtask

  task automatic test_snapshot();
    logic [15:0] c = 16'($urandom);
    logic [ND-1:0] dg = ND'($urandom);
    ad_t a = rand_ad();
    int s;
    int d;
    bq_t exp;
    a[0 +: AW] = 14'h1ABC;
    clear_mon();
    start_frame(c, dg, a, s);
    wait_bytes(5);
    ad_dat[0 +: AW] = 14'h0001;
    frame_cnt = ~c;
    digital = ~dg;
    wait_idle("snapshot");
    n_checks++;
    if (qat(got, 18) !== 8'hBC || qat(got, 19) !== 8'h1A) $display("FAIL snapshot_rec2 data %h%h want 1ABC", qat(got, 19), qat(got, 18));
    else n_pass++;
    exp = model_frame(c, dg, a);
    d = first_diff(got, exp);
    n_checks++;
    if (d != -1) $display("FAIL snapshot_frame byte %0d got %h want %h (len %0d want %0d)", d, qat(got, d), qat(exp, d), got.size(), exp.size());
    else n_pass++;
    $display("snapshot: cnt=%h bytes=%0d", c, got.size());
  endtask

  task automatic test_ena();
    logic [15:0] c = 16'($urandom);
    logic [ND-1:0] dg = ND'($urandom);
    ad_t a = rand_ad();
    int s;
    int d;
    bq_t exp;
    clear_mon();
    @(posedge clk); #1;
    ena = 1'b0;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (got.size() != 0 || ov_cnt != 0 || busy !== 1'b0) $display("FAIL ena_low_ignored bytes %0d overruns %0d busy %b, want 0/0/0", got.size(), ov_cnt, busy);
    else n_pass++;
    clear_mon();
    start_frame(c, dg, a, s);
    wait_bytes(20);
    ena = 1'b0;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    wait_idle("ena_drop");
    ena = 1'b1;
    exp = model_frame(c, dg, a);
    d = first_diff(got, exp);
    n_checks++;
    if (d != -1 || ov_cnt != 0) $display("FAIL ena_drop_frame diff at %0d (len %0d want %0d) overruns %0d want 0", d, got.size(), exp.size(), ov_cnt);
    else n_pass++;
    $display("ena: cnt=%h bytes=%0d", c, got.size());
  endtask

  task automatic test_back_to_back();
    logic [15:0] c1 = 16'($urandom);
    logic [15:0] c2 = 16'($urandom);
    logic [ND-1:0] d1 = ND'($urandom);
    logic [ND-1:0] d2 = ND'($urandom);
    ad_t a1 = rand_ad();
    ad_t a2 = rand_ad();
    int s1;
    int s2;
    int n = 0;
    int d;
    bq_t exp;
    bq_t exp2;
    clear_mon();
    start_frame(c1, d1, a1, s1);
    while (busy !== 1'b0 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    frame_cnt = c2;
    digital = d2;
    ad_dat = a2;
    frame_start = 1'b1;
    s2 = cyc;
    @(posedge clk); #1;
    frame_start = 1'b0;
    wait_idle("b2b");
    n_checks++;
    if (wen_cyc.size() < FLEN + 1 || s2 != wen_cyc[FLEN-1] + 1 || wen_cyc[FLEN] != s2 + 1)
      $display("FAIL b2b_timing restart cycle %0d, bytes %0d, want restart one cycle after last wen and %0d bytes", s2, wen_cyc.size(), 2*FLEN);
    else n_pass++;
    exp = model_frame(c1, d1, a1);
    exp2 = model_frame(c2, d2, a2);
    foreach (exp2[j]) exp.push_back(exp2[j]);
    d = first_diff(got, exp);
    n_checks++;
    if (d != -1 || ov_cnt != 0) $display("FAIL b2b_frames byte %0d got %h want %h (len %0d want %0d) overruns %0d", d, qat(got, d), qat(exp, d), got.size(), exp.size(), ov_cnt);
    else n_pass++;
    $display("back_to_back: cnt=%h,%h bytes=%0d", c1, c2, got.size());
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] c = 16'($urandom);
    logic [ND-1:0] dg = ND'($urandom);
    ad_t a = rand_ad();
    int s;
    int d;
    bq_t exp;
    clear_mon();
    start_frame(c, dg, a, s);
    wait_bytes(20);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    n_checks++;
    if (got.size() != 20 || busy !== 1'b0) $display("FAIL reset_abort bytes %0d busy %b, want 20/0", got.size(), busy);
    else n_pass++;
    $display("reset_mid: aborted after %0d bytes", got.size());
    c = 16'($urandom);
    dg = ND'($urandom);
    a = rand_ad();
    clear_mon();
    start_frame(c, dg, a, s);
    wait_idle("post_reset");
    exp = model_frame(c, dg, a);
    d = first_diff(got, exp);
    n_checks++;
    if (d != -1) $display("FAIL post_reset_frame byte %0d got %h want %h (len %0d want %0d)", d, qat(got, d), qat(exp, d), got.size(), exp.size());
    else n_pass++;
    $display("post_reset: cnt=%h bytes=%0d", c, got.size());
  endtask

  initial begin
    tx_if.tx_fifo_usedw = '0;
    test_reset();
    test_basic();
    test_random_frames();
    test_stall();
    test_stall_random();
    test_overrun();
    test_snapshot();
    test_ena();
    test_back_to_back();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
